// File: rtl/fir_decim_buf_if.sv
// Sample-stream handshake between the FIR output, the decimator and its consumer.
// The slave side is the decimator: it takes din/din_valid and presents dout/dout_valid against dout_ready.
interface fir_decim_buf_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12
);
  logic signed [IN_W-1:0]  din;
  logic                    din_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid
  );
endinterface

// File: rtl/fir_decim_buf.sv
// Integrate-and-dump decimator by 2^LOG2_DECIM with round/saturate to OUT_W bits,
// followed by a show-ahead ready/valid FIFO and sticky saturation/drop status.
module fir_decim_buf #(
  parameter int IN_W       = 14,
  parameter int OUT_W      = 12,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  fir_decim_buf_if.slave     bus,
  input  logic               phase_rst,
  input  logic               clr_flags,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               sat_flag,
  output logic               drop_flag
);

  localparam int ACC_W = IN_W + LOG2_DECIM;
  localparam int PH_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam int SHIFT = LOG2_DECIM + IN_W - OUT_W;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'((1 << LOG2_DECIM) - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  // Decimation group
  logic [PH_W-1:0]          phase;
  logic [PH_W-1:0]          phase_eff;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  din_ext;
  logic                     dump;
  logic                     dump_q;

  // Pipeline stages
  logic signed [ACC_W-1:0]  s1_sum;
  logic                     s1_vld;
  logic signed [ACC_W:0]    s1_ext;
  logic signed [ACC_W:0]    rnd;
  logic                     clip_hi;
  logic                     clip_lo;
  logic signed [OUT_W-1:0]  s2_nxt;
  logic signed [OUT_W-1:0]  s2_data;
  logic                     s2_vld;

  // FIFO
  logic signed [OUT_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr;
  logic [FIFO_AW-1:0]       rd_ptr;
  logic [FIFO_AW-1:0]       rd_nxt;
  logic [FIFO_AW:0]         level;
  logic [FIFO_AW:0]         level_nxt;
  logic [FIFO_AW:0]         remain;
  logic signed [OUT_W-1:0]  dout_r;
  logic signed [OUT_W-1:0]  dout_nxt;
  logic                     dout_valid_r;
  logic                     pop;
  logic                     push;
  logic                     sat_set;
  logic                     drop_set;

  assign din_ext = ACC_W'(bus.din);

  // phase_rst makes the current cycle behave as phase 0, so a concurrent sample starts the new group
  always_comb begin
    phase_eff = phase_rst ? '0 : phase;
    acc_nxt   = (phase_eff == '0) ? din_ext : acc + din_ext;
    dump      = bus.din_valid && (phase_eff == LAST_PH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= '0;
      acc    <= '0;
      dump_q <= 1'b0;
    end else begin
      dump_q <= dump;
      if (bus.din_valid) begin
        acc   <= acc_nxt;
        phase <= dump ? '0 : phase_eff + PH_W'(1);
      end else if (phase_rst) begin
        acc   <= '0;
        phase <= '0;
      end
    end
  end

  // Stage 1 captures the completed sum one edge after the final sample was accumulated
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_sum <= '0;
    end else begin
      s1_vld <= dump_q;
      if (dump_q) s1_sum <= acc;
    end
  end

  assign s1_ext = (ACC_W+1)'(s1_sum);

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) <<< (SHIFT - 1);
      assign rnd = (s1_ext + HALF) >>> SHIFT;
    end else begin : g_noround
      assign rnd = s1_ext;
    end
  endgenerate

  always_comb begin
    clip_hi = rnd > SAT_MAX;
    clip_lo = rnd < SAT_MIN;
    if (clip_hi)      s2_nxt = OUT_W'(SAT_MAX);
    else if (clip_lo) s2_nxt = OUT_W'(SAT_MIN);
    else              s2_nxt = OUT_W'(rnd);
    sat_set = s1_vld && (clip_hi || clip_lo);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld  <= 1'b0;
      s2_data <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_data <= s2_nxt;
    end
  end

  // Registered show-ahead head: dout_nxt is the entry that will be oldest after this edge
  always_comb begin
    pop      = dout_valid_r && bus.dout_ready;
    push     = s2_vld && (!level[FIFO_AW] || pop);
    drop_set = s2_vld && !push;
    rd_nxt   = pop ? rd_ptr + FIFO_AW'(1) : rd_ptr;
    remain   = level - (FIFO_AW+1)'(pop);
    level_nxt = level;
    if (push && !pop)      level_nxt = level + (FIFO_AW+1)'(1);
    else if (pop && !push) level_nxt = level - (FIFO_AW+1)'(1);
    dout_nxt = dout_r;
    if (remain != '0) dout_nxt = mem[rd_nxt];
    else if (push)    dout_nxt = s2_data;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      rd_ptr       <= rd_nxt;
      level        <= level_nxt;
      dout_r       <= dout_nxt;
      dout_valid_r <= level_nxt != '0;
    end
  end

  // Set has priority over a concurrent clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      sat_flag  <= sat_set  || (sat_flag  && !clr_flags);
      drop_flag <= drop_set || (drop_flag && !clr_flags);
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign fifo_level     = level;

endmodule

// File: doc/fir_decim_buf.md
# fir_decim_buf

Downstream stage of the FIR filter core: consumes the 14-bit signed filtered stream and its valid strobe (one sample every other clock at 100 MHz), decimates by a power-of-two factor with integrate-and-dump averaging, and rounds and saturates the result to 12 bits. Results are buffered in a small show-ahead FIFO with a ready/valid handshake toward the next consumer (DAC formatter or demodulator). Sticky status flags report saturation and dropped results.

## Interface
- IN_W, 14, input sample width (signed).
- OUT_W, 12, output sample width (signed); must satisfy OUT_W ≤ IN_W.
- LOG2_DECIM, 2, decimation factor R = 2^LOG2_DECIM; legal range 0..4.
- FIFO_AW, 3, FIFO address width; depth D = 2^FIFO_AW.
- clk  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- din  in  IN_W  filtered sample, signed two's complement.
- din_valid  in  1  din is qualified this cycle; any duty cycle is allowed.
- phase_rst  in  1  synchronous restart of the decimation group.
- clr_flags  in  1  synchronous clear of sat_flag and drop_flag.
- dout  out  OUT_W  FIFO head sample, signed.
- dout_valid  out  1  FIFO is not empty.
- dout_ready  in  1  consumer accepts dout; a pop occurs when dout_valid && dout_ready.
- fifo_level  out  FIFO_AW+1  number of stored entries, 0..D.
- sat_flag  out  1  sticky: a result was clipped.
- drop_flag  out  1  sticky: a result was discarded because the FIFO was full.

## Operation
- Accumulator width is IN_W+LOG2_DECIM bits, signed. A phase counter runs 0..R-1 and advances only on din_valid.
- On din_valid at phase 0, the accumulator loads din. At any other phase, it adds din.
- On din_valid at phase R-1, the complete sum is registered into stage 1 together with a dump strobe, and the phase returns to 0.
- Stage 2 computes the shift S = LOG2_DECIM + IN_W − OUT_W.
  - If S > 0: add 2^(S−1) (round half up), then arithmetic shift right by S.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Any clipped result sets sat_flag.
- Stage 3 writes the stage-2 result into the FIFO.
  - The write is accepted if fifo_level < D, or if a pop occurs in the same cycle.
  - Otherwise the result is discarded, drop_flag is set, and the FIFO contents stay unchanged.
- FIFO is show-ahead: dout always presents the oldest entry while dout_valid = 1.
  - Popping an empty FIFO has no effect.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo D; full and empty are distinguished by the extra level bit.
- phase_rst clears the phase counter and the accumulator.
  - If din_valid is asserted in the same cycle, that sample is the first sample of the new group.
  - Results already in stage 1, stage 2 or the FIFO are unaffected.
- clr_flags clears both flags. If a set event occurs in the same cycle, the set wins.
- R = 1 (LOG2_DECIM = 0): every valid sample is dumped.

## Timing
- Reset values: dout = 0, dout_valid = 0, fifo_level = 0, sat_flag = 0, drop_flag = 0. Phase, accumulator, pipeline strobes and pointers are all cleared.
- Latency: the final sample of a group is sampled at edge N. The result is registered at N+1 (stage 1) and N+2 (stage 2), written at edge N+3, and shows dout_valid = 1 in the cycle after edge N+3 (FIFO previously empty).
- dout and dout_valid are registered and change only on clk edges.
- fifo_level reflects all pushes and pops up to the last edge.
- Throughput: one result per R input samples. There is no backpressure toward din; overflow is signalled only by drop_flag.
- Reset asserted mid-group or mid-pipeline discards all partial and buffered data immediately (asynchronous assertion). After deassertion, the first din_valid is phase 0.

## Test plan
- Functional/latency: R = 4, din = 1000 on 4 valid cycles (alternating valid) → dout = 250 (sum 4000, +8, >>4). dout_valid rises 3 edges after the 4th valid sample; sat_flag stays 0.
- Rounding: din = 7 ×4 → dout = 2. din = −7 ×4 → dout = −2 (−28+8 = −20, >>4 = −2). din = 8191 ×4 → dout = 2047 with sat_flag = 1. din = −8192 ×4 → dout = −2048 with sat_flag = 0.
- FIFO full: dout_ready = 0 while 9 groups are fed → fifo_level = 8 and drop_flag = 1. Then dout_ready = 1 → exactly 8 results drain in order, fifo_level reaches 0, and dout_valid falls.
- Push/pop: dout_ready = 1 with back-to-back groups at R = 1 → fifo_level stays ≤ 1. Push and pop while full in the same cycle → the write is accepted, level stays at 8, and drop_flag stays 0.
- Control: assert phase_rst after 2 samples of value 100, together with din_valid = 1 and din = 40. Then feed 3 more samples of 40 → output 10; the stale 100s are excluded. clr_flags concurrent with a saturation event → sat_flag remains 1.
- Reset: assert reset_n low while FIFO holds 5 entries and the accumulator is mid-group → all outputs return to reset values immediately. The next 4 valid samples form a full new group.
